// File: rtl/bcd_time_pkg.sv
// Shared types and constants for the BCD HH:MM:SS to binary seconds path.
// No logic: enum, digit indices, per-step weights, default hour limit.
// Not applicable (package only).
package bcd_time_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_DIG     = 6;
  localparam int DIG_HR_MSB  = 0;
  localparam int DIG_HR_LSB  = 1;
  localparam int DIG_MIN_MSB = 2;
  localparam int DIG_MIN_LSB = 3;
  localparam int DIG_SEC_MSB = 4;
  localparam int DIG_SEC_LSB = 5;

  // Weight applied to the accumulator before adding the digit of each step.
  localparam int W [0:NUM_DIG-1] = '{10, 10, 6, 10, 6, 10};

  localparam int HR_LIMIT_DEF = 24;

  // Smallest result width holding HR_LIMIT*3600-1.
  function automatic int sec_w_min(input int hr_limit);
    return $clog2(hr_limit * 3600);
  endfunction

endpackage

// File: rtl/bcd_time_validate.sv
// Flags an illegal BCD HH:MM:SS snapshot (bad digit or hour >= HR_LIMIT).
// Latency: purely combinational.
// Backpressure: none, no handshake.
module bcd_time_validate
  import bcd_time_pkg::*;
#(
  parameter int HR_LIMIT = HR_LIMIT_DEF
) (
  input  logic [3:0] i_hr_msb,
  input  logic [3:0] i_hr_lsb,
  input  logic [3:0] i_min_msb,
  input  logic [3:0] i_min_lsb,
  input  logic [3:0] i_sec_msb,
  input  logic [3:0] i_sec_lsb,
  output logic       o_err
);

  logic [7:0] w_hr_val;

  // Hour value by shift-add (x10 = x8 + x2), then the legality checks.
  always_comb begin
    w_hr_val = {1'b0, i_hr_msb, 3'b000} + {3'b000, i_hr_msb, 1'b0} + {4'h0, i_hr_lsb};
    o_err    = (i_hr_lsb  > 4'd9) || (i_min_lsb > 4'd9) || (i_sec_lsb > 4'd9) ||
               (i_min_msb > 4'd5) || (i_sec_msb > 4'd5) || (i_hr_msb  > 4'd9) ||
               (int'(w_hr_val) >= HR_LIMIT);
  end

endmodule

// File: rtl/bcd_time_to_seconds.sv
// Converts a BCD HH:MM:SS snapshot to binary seconds, one digit per cycle.
// Latency: out_valid rises 6 edges after the accepting edge, constant.
// Backpressure: holds result in DONE until out_ready; in_ready only in IDLE.
module bcd_time_to_seconds
  import bcd_time_pkg::*;
#(
  parameter int HR_LIMIT = HR_LIMIT_DEF,
  parameter int SEC_W    = sec_w_min(HR_LIMIT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       hr_msb,
  input  logic [3:0]       hr_lsb,
  input  logic [3:0]       min_msb,
  input  logic [3:0]       min_lsb,
  input  logic [3:0]       sec_msb,
  input  logic [3:0]       sec_lsb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEC_W-1:0] out_seconds,
  output logic             out_err
);

  state_t           r_state;
  logic [3:0]       r_dig [0:NUM_DIG-1];
  logic [2:0]       r_step;
  logic [SEC_W-1:0] r_acc;
  logic             r_err;
  logic [SEC_W-1:0] r_out_seconds;
  logic             r_out_err;

  logic             w_err;
  logic [3:0]       w_dig;
  logic [SEC_W-1:0] w_acc_x10;
  logic [SEC_W-1:0] w_acc_x6;
  logic [SEC_W-1:0] w_acc_next;

  bcd_time_validate #(.HR_LIMIT(HR_LIMIT)) u_validate (
    .i_hr_msb  (hr_msb),
    .i_hr_lsb  (hr_lsb),
    .i_min_msb (min_msb),
    .i_min_lsb (min_lsb),
    .i_sec_msb (sec_msb),
    .i_sec_lsb (sec_lsb),
    .o_err     (w_err)
  );

  // One multiply-accumulate step; weights are only ever 6 or 10, so shift-add.
  always_comb begin
    w_dig      = r_dig[r_step];
    w_acc_x10  = (r_acc << 3) + (r_acc << 1);
    w_acc_x6   = (r_acc << 2) + (r_acc << 1);
    w_acc_next = ((W[r_step] == 6) ? w_acc_x6 : w_acc_x10) + {{(SEC_W-4){1'b0}}, w_dig};
  end

  // Capture in IDLE, six accumulate steps in CONV, hold the result in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_step        <= '0;
      r_acc         <= '0;
      r_err         <= 1'b0;
      r_out_seconds <= '0;
      r_out_err     <= 1'b0;
      for (int i = 0; i < NUM_DIG; i++) r_dig[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dig[DIG_HR_MSB]  <= hr_msb;
            r_dig[DIG_HR_LSB]  <= hr_lsb;
            r_dig[DIG_MIN_MSB] <= min_msb;
            r_dig[DIG_MIN_LSB] <= min_lsb;
            r_dig[DIG_SEC_MSB] <= sec_msb;
            r_dig[DIG_SEC_LSB] <= sec_lsb;
            r_err              <= w_err;
            r_acc              <= '0;
            r_step             <= '0;
            r_state            <= CONV;
          end
        end
        CONV: begin
          r_acc  <= w_acc_next;
          r_step <= r_step + 3'd1;
          if (r_step == 3'(NUM_DIG - 1)) begin
            // Illegal snapshots still take the full six steps; the sum is dropped.
            r_out_seconds <= r_err ? '0 : w_acc_next;
            r_out_err     <= r_err;
            r_state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign out_seconds = r_out_seconds;
  assign out_err     = r_out_err;

endmodule
